// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment display blocks.
//   SEG_BLANK  : all segments off (active-low bus)
//   SEG_FONT   : 16-entry hex font, active-low {dp,g,f,e,d,c,b,a}, dp off
//   hex_to_seg : nibble -> active-low segment pattern
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,   // 0 1 2 3
    8'h99, 8'h92, 8'h82, 8'hF8,   // 4 5 6 7
    8'h80, 8'h98, 8'h88, 8'h83,   // 8 9 A b
    8'hC6, 8'hA1, 8'h86, 8'h8E    // C d E F
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_FONT[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// -----------------------------------------------------------------------------
// seg7_hex_font
// Combinational hex nibble to active-low segment decoder (dp segment off).
// Ports:
//   nibble_i : 4-bit hex digit
//   seg_o    : active-low {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_segment_mux.sv
// -----------------------------------------------------------------------------
// seven_segment_mux
// Time-multiplexes NUM_DIGITS hex nibbles onto one shared, active-low segment
// bus with active-low digit strobes. Each digit slot lasts REFRESH_DIV cycles,
// the first BLANK_CYCLES of which keep every strobe off to avoid ghosting.
// New display data is captured into a pending buffer and only copied to the
// active buffer at the end of a full scan (the commit point), so a frame never
// mixes old and new data.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : one-cycle strobe, captures value/dp/enable/lz into pending
//   value_i    : nibble k drives digit k (digit 0 rightmost)
//   dp_i       : decimal point per digit
//   enable_i   : 0 forces a digit dark
//   lz_blank_i : suppress leading zeros
//   seg_o      : active-low {dp,g,f,e,d,c,b,a}
//   an_o       : active-low digit strobes, at most one low
//   frame_o    : one-cycle pulse at the commit point
//   pending_o  : pending buffer holds an uncommitted load
// -----------------------------------------------------------------------------
module seven_segment_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   enable_i,
  input  logic                    lz_blank_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Elaboration-time parameter sanity checks.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seven_segment_mux: NUM_DIGITS=%0d outside 1..8", NUM_DIGITS);
  end
  if (BLANK_CYCLES < 0) begin : g_bad_blank
    $error("seven_segment_mux: BLANK_CYCLES=%0d negative", BLANK_CYCLES);
  end
  if (REFRESH_DIV < BLANK_CYCLES + 2) begin : g_bad_div
    $error("seven_segment_mux: REFRESH_DIV=%0d < BLANK_CYCLES+2", REFRESH_DIV);
  end

  // Scan counters
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] digit_idx_q, digit_idx_d;

  // Active (displayed) buffer
  logic [4*NUM_DIGITS-1:0] act_value_q, act_value_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
  logic                    act_lz_q, act_lz_d;

  // Pending (next frame) buffer
  logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                    pend_lz_q, pend_lz_d;
  logic                    pend_valid_q, pend_valid_d;

  // Output registers
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic wrap, commit;
  logic [3:0] act_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] suppress;
  logic all_zero;
  logic [3:0] cur_nib;
  logic cur_dp, cur_en, cur_sup, lit;
  logic [7:0] font_seg;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign act_nib[gi] = act_value_q[4*gi +: 4];
  end

  // Leading-zero suppression: walk from the most significant digit down,
  // a digit is suppressed while it and everything above it is zero.
  // Digit 0 is always shown so a zero value still displays "0".
  always_comb begin
    all_zero = 1'b1;
    suppress = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (act_nib[k] == 4'h0);
      if (k != 0) suppress[k] = act_lz_q && all_zero;
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_sup = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx_q == IDX_W'(k)) begin
        cur_nib = act_nib[k];
        cur_dp  = act_dp_q[k];
        cur_en  = act_en_q[k];
        cur_sup = suppress[k];
      end
    end
  end

  seg7_hex_font u_font (
    .nibble_i (cur_nib),
    .seg_o    (font_seg)
  );

  // Counter, buffer and output next-state logic
  always_comb begin
    wrap   = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));
    commit = wrap && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));

    div_cnt_d   = wrap ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (wrap) begin
      digit_idx_d = (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
    end

    act_value_d = act_value_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    act_lz_d    = act_lz_q;
    if (commit && pend_valid_q) begin
      act_value_d = pend_value_q;
      act_dp_d    = pend_dp_q;
      act_en_d    = pend_en_q;
      act_lz_d    = pend_lz_q;
    end

    // A load on the commit cycle wins over the clear: the old pending data
    // moves to the active buffer while the new data stays pending.
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_lz_d    = pend_lz_q;
    pend_valid_d = commit ? 1'b0 : pend_valid_q;
    if (load_i) begin
      pend_value_d = value_i;
      pend_dp_d    = dp_i;
      pend_en_d    = enable_i;
      pend_lz_d    = lz_blank_i;
      pend_valid_d = 1'b1;
    end

    lit = cur_en && !cur_sup && (div_cnt_q >= CNT_W'(BLANK_CYCLES));

    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = !(lit && (digit_idx_q == IDX_W'(k)));
    end
    seg_d = lit ? {font_seg[7] & ~cur_dp, font_seg[6:0]} : SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      digit_idx_q  <= '0;
      act_value_q  <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '1;
      act_lz_q     <= 1'b0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '1;
      pend_lz_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      act_lz_q     <= act_lz_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_lz_q    <= pend_lz_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg_o     = seg_q;
  assign an_o      = an_q;
  assign frame_o   = commit;
  assign pending_o = pend_valid_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_i = 1'b0;
  logic [15:0]   value_i = '0;
  logic [3:0]    dp_i = '0;
  logic [3:0]    enable_i = '1;
  logic          lz_blank_i = 1'b0;
  logic [7:0]    seg_o;
  logic [3:0]    an_o;
  logic          frame_o;
  logic          pending_o;

  seven_segment_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .value_i    (value_i),
    .dp_i       (dp_i),
    .enable_i   (enable_i),
    .lz_blank_i (lz_blank_i),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .frame_o    (frame_o),
    .pending_o  (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame;
    logic       pend;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] font_tab [16];

  // Reference model state (mirrors DUT state before the next edge)
  int          m_cnt, m_idx;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_en, p_dp, p_en;
  logic        m_lz, p_lz, m_pv;

  // Per-frame capture
  int          lit_cnt [4];
  logic [7:0]  cap_seg [4];
  int          frames_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0;
    m_val = '0; m_dp = '0; m_en = '1; m_lz = 1'b0;
    p_val = '0; p_dp = '0; p_en = '1; p_lz = 1'b0;
    m_pv  = 1'b0;
    sb_q.delete();
  endtask

  function automatic logic lz_dark(input int k);
    if (!m_lz || k == 0) return 1'b0;
    for (int j = k; j < N; j++) if (m_val[j*4 +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: predict, push, advance, pop and compare.
  task automatic tick();
    exp_t e, g;
    logic lit;
    logic [3:0] nib;
    nib  = m_val[m_idx*4 +: 4];
    lit  = m_en[m_idx] && !lz_dark(m_idx) && (m_cnt >= BC);
    e.an = 4'hF;
    if (lit) e.an[m_idx] = 1'b0;
    e.seg = lit ? (font_tab[nib] & (m_dp[m_idx] ? 8'h7F : 8'hFF)) : 8'hFF;
    if (m_cnt == RD-1 && m_idx == N-1) begin
      if (m_pv) begin
        m_val = p_val; m_dp = p_dp; m_en = p_en; m_lz = p_lz;
      end
      m_pv = 1'b0;
    end
    if (load_i) begin
      p_val = value_i; p_dp = dp_i; p_en = enable_i; p_lz = lz_blank_i; m_pv = 1'b1;
    end
    if (m_cnt == RD-1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % N;
    end else begin
      m_cnt++;
    end
    e.frame = (m_cnt == RD-1 && m_idx == N-1);
    e.pend  = m_pv;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      g = sb_q.pop_front();
      check_eq("an", {28'd0, an_o}, {28'd0, g.an});
      check_eq("seg", {24'd0, seg_o}, {24'd0, g.seg});
      check_eq("frame", {31'd0, frame_o}, {31'd0, g.frame});
      check_eq("pending", {31'd0, pending_o}, {31'd0, g.pend});
      check_eq("an_onehot", ($countones(~an_o) <= 1) ? 1 : 0, 1);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en, input logic lz);
    value_i = v; dp_i = dp; enable_i = en; lz_blank_i = lz; load_i = 1'b1;
    $display("load value=%h dp=%b en=%b lz=%b", v, dp, en, lz);
    tick();
    load_i = 1'b0;
  endtask

  task automatic align_start();
    int n = 0;
    while (!(m_cnt == 0 && m_idx == 0) && n < 64) begin tick(); n++; end
    if (n >= 64) check_eq("align_start_timeout", 0, 1);
  endtask

  task automatic align_commit();
    int n = 0;
    while (!(m_cnt == RD-1 && m_idx == N-1) && n < 64) begin tick(); n++; end
    if (n >= 64) check_eq("align_commit_timeout", 0, 1);
  endtask

  task automatic capture_frame();
    for (int k = 0; k < N; k++) begin lit_cnt[k] = 0; cap_seg[k] = 8'hFF; end
    frames_seen = 0;
    for (int c = 0; c < N*RD; c++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (an_o[k] == 1'b0) begin lit_cnt[k]++; cap_seg[k] = seg_o; end
      end
      if (frame_o) frames_seen++;
    end
    $display("frame d3=%h d2=%h d1=%h d0=%h lit=%0d/%0d/%0d/%0d pend=%b",
             cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0],
             lit_cnt[3], lit_cnt[2], lit_cnt[1], lit_cnt[0], pending_o);
  endtask

  // exp_seg packed {d3,d2,d1,d0}; exp_lit bit k = digit k expected lit
  task automatic check_frame(input string tag, input logic [31:0] exp_seg, input logic [3:0] exp_lit);
    check_eq({tag, "_frames"}, frames_seen, 1);
    for (int k = 0; k < N; k++) begin
      if (exp_lit[k]) begin
        check_eq($sformatf("%s_lit%0d", tag, k), lit_cnt[k], RD - BC);
        check_eq($sformatf("%s_seg%0d", tag, k), {24'd0, cap_seg[k]}, {24'd0, exp_seg[k*8 +: 8]});
      end else begin
        check_eq($sformatf("%s_dark%0d", tag, k), lit_cnt[k], 0);
      end
    end
  endtask

  initial begin
    font_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    model_reset();

    // Reset state
    #1 rst = 1'b1;
    #2;
    check_eq("rst_an", {28'd0, an_o}, 32'hF);
    check_eq("rst_seg", {24'd0, seg_o}, 32'hFF);
    check_eq("rst_frame", {31'd0, frame_o}, 0);
    check_eq("rst_pending", {31'd0, pending_o}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Idle scan of zeros
    capture_frame();
    check_frame("idle", 32'hC0C0C0C0, 4'b1111);

    // Mid-frame load becomes visible only after the commit
    repeat (10) tick();
    do_load(16'h12AF, 4'b0000, 4'b1111, 1'b0);
    check_eq("load_pending", {31'd0, pending_o}, 1);
    align_start();
    capture_frame();
    check_frame("hex12AF", 32'hF9A4888E, 4'b1111);
    check_eq("commit_pending_clr", {31'd0, pending_o}, 0);

    // Leading-zero suppression
    do_load(16'h0050, 4'b0000, 4'b1111, 1'b1);
    align_start();
    capture_frame();
    check_frame("lz0050", 32'hFFFF92C0, 4'b0011);

    do_load(16'h0000, 4'b0000, 4'b1111, 1'b1);
    align_start();
    capture_frame();
    check_frame("lz0000", 32'hFFFFFFC0, 4'b0001);

    // Per-digit enable and decimal point
    do_load(16'h0000, 4'b0011, 4'b1010, 1'b0);
    align_start();
    capture_frame();
    check_frame("en_dp", 32'hC0FF40FF, 4'b1010);

    // Last load wins; load on the commit cycle stays pending for one frame
    repeat (5) tick();
    do_load(16'h1111, 4'b0000, 4'b1111, 1'b0);
    repeat (3) tick();
    do_load(16'h2222, 4'b0000, 4'b1111, 1'b0);
    align_commit();
    do_load(16'h3333, 4'b0000, 4'b1111, 1'b0);
    check_eq("commit_load_pending", {31'd0, pending_o}, 1);
    capture_frame();
    check_frame("last2222", 32'hA4A4A4A4, 4'b1111);
    check_eq("after_commit_load_pend", {31'd0, pending_o}, 0);
    capture_frame();
    check_frame("then3333", 32'hB0B0B0B0, 4'b1111);

    // Asynchronous reset mid-slot with a load pending
    repeat (12) tick();
    do_load(16'h5555, 4'b1111, 4'b1111, 1'b0);
    check_eq("pre_rst_pending", {31'd0, pending_o}, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_an", {28'd0, an_o}, 32'hF);
    check_eq("async_rst_seg", {24'd0, seg_o}, 32'hFF);
    check_eq("async_rst_pending", {31'd0, pending_o}, 0);
    check_eq("async_rst_frame", {31'd0, frame_o}, 0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    capture_frame();
    check_frame("post_rst", 32'hC0C0C0C0, 4'b1111);
    check_eq("post_rst_pending", {31'd0, pending_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
